// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and write-controller state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDRW  = $clog2(FB_PIXELS);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_write_ctrl_if.sv
// Drawing-pixel stream: signed (x, y) coordinates plus colour with valid/ready.
// Latency: n/a (wires only).
// Backpressure: the slave holds off the master by keeping pix_ready low.
interface fb_write_ctrl_if #(
  parameter int CORDW    = 16,
  parameter int FB_DATAW = 1
);
  logic                       pix_valid;
  logic                       pix_ready;
  logic signed [CORDW-1:0]    pix_x;
  logic signed [CORDW-1:0]    pix_y;
  logic        [FB_DATAW-1:0] pix_colr;

  modport master (
    output pix_valid, pix_x, pix_y, pix_colr,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_colr,
    output pix_ready
  );
endinterface

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-port arbiter: full-buffer clear engine vs. drawing pixel stream.
// Latency: one cycle from pixel handshake or clear step to the registered BRAM write.
// Backpressure: pix_ready low while clearing, on clear_req, or outside the write window.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int                  FB_DATAW    = 1,
  parameter int                  CORDW       = 16,
  parameter logic [FB_DATAW-1:0] CLR_COLR    = '0,
  parameter bit                  VBLANK_ONLY = 1'b0
) (
  input  logic                clk_pix,
  input  logic                rst_pix,
  input  logic                vbl,
  input  logic                clear_req,
  fb_write_ctrl_if.slave      pix,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr_write,
  output logic [FB_DATAW-1:0] fb_colr_write,
  output logic                busy,
  output logic                clear_done
);

  localparam logic [FB_ADDRW-1:0]  LAST_ADDR = FB_ADDRW'(FB_PIXELS - 1);
  localparam logic [FB_ADDRW-1:0]  WIDTH_A   = FB_ADDRW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] WIDTH_C  = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] HEIGHT_C = CORDW'(FB_HEIGHT);

  fb_state_e           state_q, state_d;
  logic [FB_ADDRW-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [FB_ADDRW-1:0] addr_q, addr_d;
  logic [FB_DATAW-1:0] colr_q, colr_d;
  logic                done_q, done_d;
  logic                pix_rdy;

  logic                permit;
  logic                in_range;
  logic                clr_last;
  logic [FB_ADDRW-1:0] pix_addr;

  // Writes are gated to vertical blanking only when built tear-free.
  assign permit = VBLANK_ONLY ? vbl : 1'b1;

  // Range check on signed coordinates; sign bit set means negative, always off-buffer.
  assign in_range = !pix.pix_x[CORDW-1] && (pix.pix_x < WIDTH_C) &&
                    !pix.pix_y[CORDW-1] && (pix.pix_y < HEIGHT_C);

  // Linear address only formed for in-range pixels, so the unsigned product never wraps.
  assign pix_addr = in_range ? (FB_ADDRW'(pix.pix_y) * WIDTH_A + FB_ADDRW'(pix.pix_x))
                             : '0;

  // Final clear write happens on a permitted step at the last address.
  assign clr_last = (state_q == CLEAR) && permit && (cnt_q == LAST_ADDR);

  // State register; reset aborts any clear in progress.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: clear_req starts a clear from IDLE; the final clear write ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (clr_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: arbitrate the write port; clear owns it entirely while in CLEAR.
  always_comb begin
    pix_rdy = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    colr_d  = colr_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pix_rdy = permit && !clear_req;
        if (clear_req) begin
          cnt_d = '0;
        end else if (pix.pix_valid && permit && in_range) begin
          we_d   = 1'b1;
          addr_d = pix_addr;
          colr_d = pix.pix_colr;
        end
      end
      CLEAR: begin
        if (permit) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          colr_d = CLR_COLR;
          done_d = clr_last;
          cnt_d  = clr_last ? '0 : cnt_q + FB_ADDRW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered BRAM write port, clear counter and done pulse.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      colr_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      colr_q <= colr_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pix.pix_ready  = pix_rdy;
  assign fb_we          = we_q;
  assign fb_addr_write  = addr_q;
  assign fb_colr_write  = colr_q;
  assign clear_done     = done_q;
  assign busy           = (state_q == CLEAR);

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: two instances (free-running and vblank-gated) share stimulus.
// Latency: expected writes are queued per instance with the cycle they must appear in.
// Backpressure: expected pix_ready derived from model clear state, permit and clear_req.
module tb_fb_write_ctrl;
  import fb_pkg::*;

  typedef struct {
    int cyc;
    int addr;
    int colr;
    bit done;
  } wr_t;

  logic clk_pix = 1'b0;
  logic rst_pix;
  logic vbl;
  logic clear_req;
  logic pix_valid;
  logic signed [15:0] pix_x, pix_y;
  logic [3:0] pix_colr;

  logic                we0, we1, busy0, busy1, done0, done1;
  logic [FB_ADDRW-1:0] addr0, addr1;
  logic [0:0]          colr0;
  logic [3:0]          colr1;

  fb_write_ctrl_if #(.CORDW(16), .FB_DATAW(1)) pix0 ();
  fb_write_ctrl_if #(.CORDW(16), .FB_DATAW(4)) pix1 ();

  assign pix0.pix_valid = pix_valid;
  assign pix0.pix_x     = pix_x;
  assign pix0.pix_y     = pix_y;
  assign pix0.pix_colr  = pix_colr[0];
  assign pix1.pix_valid = pix_valid;
  assign pix1.pix_x     = pix_x;
  assign pix1.pix_y     = pix_y;
  assign pix1.pix_colr  = pix_colr;

  fb_write_ctrl #(.FB_DATAW(1), .CORDW(16), .CLR_COLR(1'b0), .VBLANK_ONLY(1'b0)) dut0 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .vbl(vbl), .clear_req(clear_req), .pix(pix0),
    .fb_we(we0), .fb_addr_write(addr0), .fb_colr_write(colr0), .busy(busy0), .clear_done(done0)
  );

  fb_write_ctrl #(.FB_DATAW(4), .CORDW(16), .CLR_COLR(4'hA), .VBLANK_ONLY(1'b1)) dut1 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .vbl(vbl), .clear_req(clear_req), .pix(pix1),
    .fb_we(we1), .fb_addr_write(addr1), .fb_colr_write(colr1), .busy(busy1), .clear_done(done1)
  );

  always #5 clk_pix = ~clk_pix;

  // Reference model state: per instance, whether a clear is running and the next address.
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  clearing [2];
  int  nxt [2];
  wr_t q0 [$];
  wr_t q1 [$];
  int  clr_val [2] = '{0, 10};
  int  colr_mask [2] = '{1, 15};

  function automatic bit permit_of(input int d);
    return (d == 0) ? 1'b1 : vbl;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic wr_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int d, input wr_t w);
    if (d == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  task automatic qdrop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qflush(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic chk(input int d, input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d want %0d", name, d, cyc, got, want);
    end
  endtask

  // Behavioural model: a clear is a walk over 0..FB_PIXELS-1 advancing on permitted cycles;
  // otherwise an offered, permitted, on-screen pixel becomes one write at y*W+x.
  task automatic model_step(input int d);
    wr_t w;
    int  xi, yi;
    bit  p;
    p = permit_of(d);
    if (rst_pix) begin
      clearing[d] = 1'b0;
      nxt[d] = 0;
      return;
    end
    if (clearing[d]) begin
      if (p) begin
        w = '{cyc: cyc, addr: nxt[d], colr: clr_val[d], done: (nxt[d] == FB_PIXELS - 1)};
        qpush(d, w);
        nxt[d]++;
        if (nxt[d] == FB_PIXELS) clearing[d] = 1'b0;
      end
    end else if (clear_req) begin
      clearing[d] = 1'b1;
      nxt[d] = 0;
    end else if (pix_valid && p) begin
      xi = pix_x;
      yi = pix_y;
      if (xi >= 0 && xi < FB_WIDTH && yi >= 0 && yi < FB_HEIGHT) begin
        w = '{cyc: cyc, addr: yi * FB_WIDTH + xi, colr: int'(pix_colr) & colr_mask[d], done: 1'b0};
        qpush(d, w);
      end
    end
  endtask

  always @(posedge clk_pix) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // Monitor: compares DUT outputs against the queued expectations mid-cycle.
  task automatic check_dut(input int d, input bit we, input int addr, input int colr,
                           input bit done, input bit busy, input bit rdy);
    wr_t w;
    bit  exp_rdy;
    if (rst_pix) begin
      chk(d, "reset_we_busy_done", {29'd0, we, busy, done}, 0);
      chk(d, "reset_addr", addr, 0);
      chk(d, "reset_colr", colr, 0);
      qflush(d);
      return;
    end
    while (qsize(d) > 0 && qfront(d).cyc < cyc) begin
      w = qfront(d);
      checks++;
      errors++;
      $display("FAIL missed_write dut%0d cyc %0d: got no write want addr %0d in cyc %0d",
               d, cyc, w.addr, w.cyc);
      qdrop(d);
    end
    exp_rdy = !clearing[d] && permit_of(d) && !clear_req;
    chk(d, "pix_ready", int'(rdy), int'(exp_rdy));
    chk(d, "busy", int'(busy), int'(clearing[d]));
    if (we) begin
      checks++;
      if (qsize(d) == 0) begin
        errors++;
        $display("FAIL unexpected_write dut%0d cyc %0d: got addr %0d want no write", d, cyc, addr);
      end else begin
        w = qfront(d);
        qdrop(d);
        if (w.cyc != cyc || w.addr != addr || w.colr != colr || w.done != done) begin
          errors++;
          $display("FAIL write dut%0d cyc %0d: got cyc %0d addr %0d colr %0d done %0d want cyc %0d addr %0d colr %0d done %0d",
                   d, cyc, cyc, addr, colr, done, w.cyc, w.addr, w.colr, w.done);
        end
      end
    end else if (done) begin
      checks++;
      errors++;
      $display("FAIL clear_done_without_we dut%0d cyc %0d: got 1 want 0", d, cyc);
    end
  endtask

  always @(negedge clk_pix) begin
    check_dut(0, we0, int'(addr0), int'(colr0), done0, busy0, pix0.pix_ready);
    check_dut(1, we1, int'(addr1), int'(colr1), done1, busy1, pix1.pix_ready);
  end

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y, input int c);
    pix_valid = 1'b1;
    pix_x     = 16'(x);
    pix_y     = 16'(y);
    pix_colr  = 4'(c);
    step();
  endtask

  task automatic rand_pix(input int lo, input int hi);
    pix_valid = ($urandom_range(0, 3) != 0);
    pix_x     = 16'(int'($urandom_range(0, 200)) + lo);
    pix_y     = 16'(int'($urandom_range(0, hi)) + lo);
    pix_colr  = 4'($urandom);
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s cyc %0d: got still waiting want event", name, cyc);
  endtask

  initial begin
    int n;
    rst_pix = 1'b1; vbl = 1'b1; clear_req = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_colr = '0;
    repeat (3) step();
    rst_pix = 1'b0;
    step();

    // Directed pixels: single write, corners back-to-back, off-buffer drops.
    drive_pix(10, 2, 1);
    pix_valid = 1'b0; step(); step();
    drive_pix(159, 119, 5);
    drive_pix(0, 0, 3);
    pix_valid = 1'b0; step();
    drive_pix(-1, 5, 1);
    drive_pix(160, 0, 1);
    drive_pix(3, 120, 1);
    drive_pix(-32768, -1, 1);
    pix_valid = 1'b0; step(); step();

    // Random drawing; vbl randomly closes the write window of the gated instance.
    repeat (400) begin
      rand_pix(-20, 160);
      vbl = ($urandom_range(0, 2) != 0);
      step();
    end

    // Clear with permit high, pixel offered in the same cycle, re-request mid-clear ignored.
    vbl = 1'b1; clear_req = 1'b1; pix_valid = 1'b1; pix_x = 16'sd10; pix_y = 16'sd10;
    step();
    clear_req = 1'b0;
    n = 0;
    while ((busy0 || busy1) && n < 20000) begin
      rand_pix(0, 119);
      clear_req = (n == 1000);
      step();
      n++;
    end
    clear_req = 1'b0;
    if (n >= 20000) timeout("clear_permit_high");
    pix_valid = 1'b0; step(); step();

    // Clear with vbl toggling and pixels held; the gated instance stalls and resumes.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n = 0;
    while ((busy0 || busy1) && n < 40000) begin
      vbl = ($urandom_range(0, 3) != 0);
      pix_valid = 1'b1;
      pix_x = 16'($urandom_range(0, 159));
      pix_y = 16'($urandom_range(0, 119));
      pix_colr = 4'($urandom);
      step();
      n++;
    end
    if (n >= 40000) timeout("clear_vbl_toggle");
    vbl = 1'b1; pix_valid = 1'b0; step(); step();

    // Clear collides with a pixel, then reset lands mid-clear at address 5000.
    clear_req = 1'b1; pix_valid = 1'b1; pix_x = 16'sd4; pix_y = 16'sd4; pix_colr = 4'h1;
    step();
    clear_req = 1'b0; pix_valid = 1'b0;
    n = 0;
    while (!(we0 && addr0 == FB_ADDRW'(5000)) && n < 6000) begin
      step();
      n++;
    end
    if (n >= 6000) timeout("clear_addr_5000");
    rst_pix = 1'b1;
    step(); step();
    rst_pix = 1'b0;
    repeat (30) step();

    // Drawing works again after the aborted clear.
    drive_pix(10, 2, 1);
    drive_pix(100, 50, 6);
    pix_valid = 1'b0;
    repeat (4) step();

    chk(0, "queue_drained", qsize(0), 0);
    chk(1, "queue_drained", qsize(1), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
